sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8x8 FIFO.
//  Generic data width and depth, programmable almost-full/almost-empty levels, occupancy count output.
//  Registered read data with a valid strobe; sticky overrun/underrun flags with a clear input.
//  Sits between producer/consumer blocks in one clock domain.
// PARAMETERS
//  DATA_W    8  data width in bits (>=1)
//  DEPTH     8  number of entries; power of 2, >=2
//  AF_LEVEL  6  fifo_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2  fifo_almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk                in   1          rising-edge clock
//  rst_n              in   1          asynchronous active-low reset
//  wr_enb             in   1          write request
//  wr_data            in   DATA_W     write data, sampled when write accepted
//  rd_enb             in   1          read request
//  rd_data            out  DATA_W     registered read data
//  rd_valid           out  1          rd_data updated this cycle (1-cycle pulse)
//  err_clr            in   1          clears sticky overrun/underrun
//  fifo_count         out  CW         occupancy, 0..DEPTH; CW=$clog2(DEPTH)+1
//  fifo_full          out  1          count == DEPTH
//  fifo_empty         out  1          count == 0
//  fifo_almost_full   out  1          count >= AF_LEVEL
//  fifo_almost_empty  out  1          count <= AE_LEVEL
//  fifo_overrun       out  1          sticky: write attempted while full and not accepted
//  fifo_underrun      out  1          sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async, rst_n=0): pointers=0, count=0, rd_data=0, rd_valid=0, overrun=0, underrun=0.
//    Outputs: empty=1, almost_empty=1 (AE_LEVEL>=0), full=0, almost_full=0.
//    Memory contents are not reset. Reset mid-operation discards all entries immediately.
//  - wr_ok = wr_enb & (!full | rd_ok). rd_ok = rd_enb & !empty.
//  - Accepted write: mem[wptr] <= wr_data. wptr increments mod DEPTH (natural wrap; pointers are log2(DEPTH) bits).
//  - Accepted read: rd_data <= mem[rptr], rptr increments mod DEPTH, rd_valid=1 on the next cycle.
//    Latency: data appears the clock edge after rd_enb is sampled. rd_data holds its value otherwise.
//  - count: +1 on wr_ok only; -1 on rd_ok only; unchanged if both or neither.
//  - All status flags decode the registered count, so they reflect the state after the edge.
//  - Full + rd_enb + wr_enb: both are accepted, count stays DEPTH, no overrun.
//  - Empty + rd_enb + wr_enb: the read is rejected (underrun set) and the write is accepted, so count becomes 1.
//    There is no fall-through; the written word is read on a later request.
//  - Full + wr_enb without a read: write dropped, memory unchanged, overrun <= 1.
//  - Empty + rd_enb: rd_data unchanged, rd_valid=0, underrun <= 1.
//  - Sticky flags hold until err_clr=1 at a clock edge, which clears them to 0.
//    If err_clr coincides with a new error event, the flag ends at 1 (set wins).
//  - Flags are visible the cycle after the offending request.
// TESTING
//  T1 reset: rst_n=0 for 2 clks -> count=0, empty=1, almost_empty=1, full=0, over=under=0, rd_data=0.
//  T2 single: write 8'hA5, then read -> rd_data=A5 with rd_valid=1 one cycle after rd_enb; count 0->1->0.
//  T3 fill/overrun: write 8'h10..8'h17 (DEPTH=8), then write 8'hFF.
//     -> almost_full at count=6, full at 8, overrun=1, count stays 8.
//     Draining returns 10..17 in order; FF never appears.
//  T4 drain/underrun: read from empty -> underrun=1, rd_valid=0, rd_data unchanged.
//     Then err_clr -> over=under=0.
//  T5 simultaneous: at full, rd+wr 8'h55 -> count=8, no overrun, 55 read last.
//     At empty, rd+wr 8'h66 -> underrun=1, count=1, next read returns 66.
//  T6 wrap/reset: 20 interleaved write/read pairs cross the pointer wrap -> data order preserved.
//     rst_n pulsed low with count=5 -> count=0 and empty=1 immediately.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data,
// programmable almost-full/empty levels and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_enb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_enb,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              err_clr,
  output logic [CW-1:0]     fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overrun,
  output logic              fifo_underrun
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              over_q, over_d;
  logic              under_q, under_d;
  logic              wr_ok, rd_ok;
  logic              full, empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A read frees a slot in the same cycle, so a write at full
  // is still accepted when paired with a read.
  assign rd_ok = rd_enb & ~empty;
  assign wr_ok = wr_enb & (~full | rd_ok);

  // Next-state for pointers, occupancy, read port and error flags.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_ok;
    over_d     = over_q;
    under_d    = under_q;

    if (wr_ok) wptr_d = wptr_q + AW'(1);
    if (rd_ok) begin
      rptr_d    = rptr_q + AW'(1);
      rd_data_d = mem_q[rptr_q];
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so a coincident new error wins.
    if (err_clr) begin
      over_d  = 1'b0;
      under_d = 1'b0;
    end
    if (wr_enb & ~wr_ok)  over_d  = 1'b1;
    if (rd_enb & empty)   under_d = 1'b1;
  end

  // Control and status registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      over_q     <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      over_q     <= over_d;
      under_q    <= under_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data           = rd_data_q;
  assign rd_valid          = rd_valid_q;
  assign fifo_count        = count_q;
  assign fifo_full         = full;
  assign fifo_empty        = empty;
  assign fifo_almost_full  = (count_q >= CW'(AF_LEVEL));
  assign fifo_almost_empty = (count_q <= CW'(AE_LEVEL));
  assign fifo_overrun      = over_q;
  assign fifo_underrun     = under_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DATA_W=8, DEPTH=8).
// Read data is checked by a monitor against a queue of expected words.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_enb;
  logic [7:0] wr_data;
  logic       rd_enb;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       err_clr;
  logic [3:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_almost_full;
  logic       fifo_almost_empty;
  logic       fifo_overrun;
  logic       fifo_underrun;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q [$];

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_enb(wr_enb),
    .wr_data(wr_data),
    .rd_enb(rd_enb),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .err_clr(err_clr),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_overrun(fifo_overrun),
    .fifo_underrun(fifo_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_unexpected: got %0h expected none", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data === e) passed++;
        else $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
      end
    end
  end

  // One clock with the given request; returns #1 after the edge.
  task automatic drive(input logic w, input logic [7:0] d,
                       input logic r, input logic c);
    wr_enb  = w;
    wr_data = d;
    rd_enb  = r;
    err_clr = c;
    @(posedge clk);
    #1;
    wr_enb  = 1'b0;
    rd_enb  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] expv);
    exp_q.push_back(expv);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rd_valid_lat", rd_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_enb = 0; rd_enb = 0; err_clr = 0; wr_data = 0;
    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_ae", fifo_almost_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_af", fifo_almost_full, 0);
    chk("rst_over", fifo_overrun, 0);
    chk("rst_under", fifo_underrun, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rvalid", rd_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T2 single word
    wr(8'hA5);
    chk("t2_count1", fifo_count, 1);
    chk("t2_empty0", fifo_empty, 0);
    rd(8'hA5);
    chk("t2_count0", fifo_count, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_pulse", rd_valid, 0);
    chk("t2_hold", rd_data, 8'hA5);

    // T3 fill then overrun
    for (int i = 0; i < 8; i++) begin
      wr(8'h10 + 8'(i));
      chk("t3_count", fifo_count, i + 1);
      chk("t3_af", fifo_almost_full, (i + 1 >= 6) ? 1 : 0);
      chk("t3_ae", fifo_almost_empty, (i + 1 <= 2) ? 1 : 0);
      chk("t3_full", fifo_full, (i == 7) ? 1 : 0);
    end
    chk("t3_over0", fifo_overrun, 0);
    wr(8'hFF);
    chk("t3_over1", fifo_overrun, 1);
    chk("t3_count8", fifo_count, 8);
    for (int i = 0; i < 8; i++) rd(8'h10 + 8'(i));
    chk("t3_drained", fifo_empty, 1);

    // T4 underrun then clear
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_under", fifo_underrun, 1);
    chk("t4_rvalid", rd_valid, 0);
    chk("t4_hold", rd_data, 8'h17);
    chk("t4_over_sticky", fifo_overrun, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_clr_over", fifo_overrun, 0);
    chk("t4_clr_under", fifo_underrun, 0);

    // T5 simultaneous at full and at empty
    for (int i = 0; i < 8; i++) wr(8'h20 + 8'(i));
    exp_q.push_back(8'h20);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t5_full_count", fifo_count, 8);
    chk("t5_full_over", fifo_overrun, 0);
    chk("t5_full_rv", rd_valid, 1);
    for (int i = 1; i < 8; i++) rd(8'h20 + 8'(i));
    rd(8'h55);
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    chk("t5_emp_under", fifo_underrun, 1);
    chk("t5_emp_count", fifo_count, 1);
    chk("t5_emp_rv", rd_valid, 0);
    rd(8'h66);
    // clear coinciding with a fresh underrun: set wins
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_setwins", fifo_underrun, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_clr", fifo_underrun, 0);

    // T6 interleaved pairs across pointer wrap
    wr(8'h80);
    for (int i = 1; i < 20; i++) begin
      exp_q.push_back(8'h80 + 8'(i - 1));
      drive(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
      chk("t6_count", fifo_count, 1);
    end
    rd(8'h93);
    chk("t6_empty", fifo_empty, 1);

    // Async reset with five words queued
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    chk("t6_count5", fifo_count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_empty", fifo_empty, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_post_rst", fifo_count, 0);
    chk("t6_post_rd", rd_data, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
